// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives the enable and ratio-load request; the slave (the divider)
// returns the divided clock and its status pulses.
interface clk_div_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic [CNT_W-1:0] high_val;
  logic             clk_out;
  logic             tick;
  logic             per_end;
  logic             upd_pend;

  modport master (
    output en, div_load, div_val, high_val,
    input  clk_out, tick, per_end, upd_pend
  );

  modport slave (
    input  en, div_load, div_val, high_val,
    output clk_out, tick, per_end, upd_pend
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider with period N and high time H, both in clk cycles.
// A phase counter runs 0..N-1.  clk_out is high in the last H cycles of each
// period.  New ratios are clamped, parked in shadow registers and only
// applied at a period boundary, so a period is never cut short or stretched.
module clk_div_prog #(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 4,
  parameter int DEF_HIGH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  clk_div_prog_if.slave div_if
);

  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] n_act_q, n_act_d;
  logic [CNT_W-1:0] h_act_q, h_act_d;
  logic [CNT_W-1:0] n_sh_q, n_sh_d;
  logic [CNT_W-1:0] h_sh_q, h_sh_d;
  logic             upd_pend_q, upd_pend_d;
  logic             clk_out_q, clk_out_d;

  logic [CNT_W-1:0] n_clamp;
  logic [CNT_W-1:0] h_clamp;
  logic             boundary;

  // Clamp the requested ratio: N >= 2 and 1 <= H <= N-1, so N-H >= 1 always.
  always_comb begin
    n_clamp = (div_if.div_val < CNT_W'(2)) ? CNT_W'(2) : div_if.div_val;
    if (div_if.high_val == '0)
      h_clamp = CNT_W'(1);
    else if (div_if.high_val >= n_clamp)
      h_clamp = n_clamp - CNT_W'(1);
    else
      h_clamp = div_if.high_val;
  end

  // Next-state: advance phase, swap in new settings only at a period boundary.
  always_comb begin
    boundary   = div_if.en && (ph_q == n_act_q - CNT_W'(1));
    ph_d       = ph_q;
    n_act_d    = n_act_q;
    h_act_d    = h_act_q;
    n_sh_d     = n_sh_q;
    h_sh_d     = h_sh_q;
    upd_pend_d = upd_pend_q;

    if (div_if.en) begin
      if (boundary) begin
        // Shadow equals active when nothing is pending, so always copying is safe.
        ph_d       = '0;
        n_act_d    = div_if.div_load ? n_clamp : n_sh_q;
        h_act_d    = div_if.div_load ? h_clamp : h_sh_q;
        upd_pend_d = 1'b0;
      end else begin
        ph_d = ph_q + CNT_W'(1);
      end
    end

    if (div_if.div_load) begin
      n_sh_d = n_clamp;
      h_sh_d = h_clamp;
      if (!boundary) upd_pend_d = 1'b1;
    end

    // Derived from next phase and next settings so the output flop is glitch-free.
    clk_out_d = (ph_d >= n_act_d - h_act_d);
  end

  // State registers with synchronous reset to the default ratio.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q       <= '0;
      n_act_q    <= CNT_W'(DEF_DIV);
      h_act_q    <= CNT_W'(DEF_HIGH);
      n_sh_q     <= CNT_W'(DEF_DIV);
      h_sh_q     <= CNT_W'(DEF_HIGH);
      upd_pend_q <= 1'b0;
      clk_out_q  <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      n_act_q    <= n_act_d;
      h_act_q    <= h_act_d;
      n_sh_q     <= n_sh_d;
      h_sh_q     <= h_sh_d;
      upd_pend_q <= upd_pend_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign div_if.clk_out  = clk_out_q;
  assign div_if.upd_pend = upd_pend_q;
  assign div_if.tick     = div_if.en && (ph_q == n_act_q - h_act_q);
  assign div_if.per_end  = boundary;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: a period-queue reference model checked every cycle,
// plus directed scenarios pinned with hand-computed waveforms.
module tb_clk_div_prog;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_div_prog_if #(.CNT_W(W)) dif ();

  clk_div_prog #(.CNT_W(W), .DEF_DIV(4), .DEF_HIGH(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_if (dif)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Each period is expanded into a queue of cycles (high flag, rising flag);
  // an enabled cycle consumes one entry, an empty queue means the period ends.
  typedef struct { bit c; bit t; } ent_t;
  ent_t q[$];
  ent_t cur;
  int   m_n, m_h, p_n, p_h;
  bit   m_pend;
  bit   m_init = 0;

  function automatic void clampv(input int dv, input int hv, output int n, output int h);
    n = (dv < 2) ? 2 : dv;
    if (hv == 0)       h = 1;
    else if (hv >= n)  h = n - 1;
    else               h = hv;
  endfunction

  function automatic void start_period();
    ent_t e;
    q.delete();
    for (int i = 0; i < m_n; i++) begin
      e.c = (i >= m_n - m_h);
      e.t = (i == m_n - m_h);
      q.push_back(e);
    end
    cur = q.pop_front();
  endfunction

  always @(posedge clk) begin
    int cn, ch;
    bit bnd;
    if (rst) begin
      m_init = 1;
      m_n = 4; m_h = 2; m_pend = 0;
      start_period();
    end else if (m_init) begin
      clampv(int'(dif.div_val), int'(dif.high_val), cn, ch);
      bnd = dif.en && (q.size() == 0);
      if (dif.en) begin
        if (bnd) begin
          if (dif.div_load) begin m_n = cn; m_h = ch; end
          else if (m_pend) begin m_n = p_n; m_h = p_h; end
          m_pend = 0;
          start_period();
        end else begin
          cur = q.pop_front();
        end
      end
      if (dif.div_load && !bnd) begin
        m_pend = 1; p_n = cn; p_h = ch;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init && !rst) begin
      chk("clk_out",  32'(dif.clk_out),  32'(cur.c));
      chk("tick",     32'(dif.tick),     32'(dif.en && cur.t));
      chk("per_end",  32'(dif.per_end),  32'(dif.en && q.size() == 0));
      chk("upd_pend", 32'(dif.upd_pend), 32'(m_pend));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] sc, st, sp, su;

  task automatic run(input int n);
    sc = 0; st = 0; sp = 0; su = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sc = {sc[30:0], dif.clk_out};
      st = {st[30:0], dif.tick};
      sp = {sp[30:0], dif.per_end};
      su = {su[30:0], dif.upd_pend};
      #2;
    end
  endtask

  task automatic ld(input logic l, input int dv, input int hv);
    dif.div_load = l;
    dif.div_val  = W'(dv);
    dif.high_val = W'(hv);
  endtask

  initial begin
    rst = 1'b1; dif.en = 1'b0; ld(0, 0, 0);

    // Reset state
    run(2);
    chk("rst_clk_out", sc, 32'b00);
    chk("rst_upd_pend", su, 32'b00);
    chk("rst_tick", st, 32'b00);

    // Defaults: period 4, 2 low / 2 high
    rst = 1'b0; dif.en = 1'b1;
    run(8);
    chk("def_clk_out", sc, 32'b01100110);
    chk("def_tick",    st, 32'b01000100);
    chk("def_per_end", sp, 32'b00100010);

    // Mid-period load at ph=1: old period completes, then 7 low / 3 high
    run(1);
    ld(1, 10, 3);
    run(1);
    chk("mid_upd_set", su, 32'b1);
    ld(0, 10, 3);
    run(11);
    chk("mid_clk_out",  sc, 32'b10000000111);
    chk("mid_upd_pend", su, 32'b10000000000);
    chk("mid_tick",     st, 32'b00000000100);
    chk("mid_per_end",  sp, 32'b10000000001);

    // Clamp 1/5 -> N=2,H=1, loaded exactly at the boundary
    ld(1, 1, 5);
    run(1);
    chk("clamp_first", {sc[0], su[0]}, 32'b00);
    ld(0, 1, 5);
    run(5);
    chk("clamp_clk_out", sc, 32'b10101);
    chk("clamp_tick",    st, 32'b10101);

    // N=8,H=5, pause 5 cycles in the high phase
    ld(1, 8, 5);
    run(1);
    ld(0, 8, 5);
    run(3);
    chk("pause_pre_clk", sc, 32'b001);
    dif.en = 1'b0;
    run(5);
    chk("pause_clk_out", sc, 32'b11111);
    chk("pause_tick",    st, 32'b00000);
    chk("pause_per_end", sp, 32'b00000);
    dif.en = 1'b1;
    run(5);
    chk("resume_clk_out", sc, 32'b11110);
    chk("resume_per_end", sp, 32'b00010);

    // Pending load discarded by reset, even with a simultaneous load
    ld(1, 8, 4);
    run(1);
    chk("rstld_pend", su, 32'b1);
    ld(1, 3, 1); rst = 1'b1;
    run(1);
    chk("rstld_after", {sc[0], su[0]}, 32'b00);
    ld(0, 3, 1); rst = 1'b0;
    run(8);
    chk("rstld_clk_out", sc, 32'b01100110);
    chk("rstld_upd",     su, 32'b0);
    chk("rstld_per_end", sp, 32'b00100010);

    // Boundary-coincident load 6/6 at ph=3 -> 1 low / 5 high, never pending
    run(3);
    ld(1, 6, 6);
    run(1);
    chk("bnd_first", {sc[0], su[0]}, 32'b00);
    ld(0, 6, 6);
    run(6);
    chk("bnd_clk_out", sc, 32'b111110);
    chk("bnd_tick",    st, 32'b100000);
    chk("bnd_upd",     su, 32'b0);

    // Two loads before a boundary: the last one (5/2) wins
    ld(1, 3, 1);
    run(1);
    ld(1, 5, 2);
    run(1);
    ld(0, 5, 2);
    run(9);
    chk("last_clk_out", sc, 32'b111000110);
    chk("last_upd",     su, 32'b111000000);

    // Zero inputs clamp to N=2,H=1; model-checked only
    ld(1, 0, 0);
    run(1);
    ld(0, 0, 0);
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CNT_W, default 16: width of the divide-ratio, high-time and phase-counter fields.
REQ-002 Parameter DEF_DIV, default 4: period in clk cycles after reset (100 MHz -> 25 MHz).
REQ-003 Parameter DEF_HIGH, default 2: high time in clk cycles after reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; when low, all state holds.
REQ-007 div_load  input  1  single-cycle request to capture div_val/high_val.
REQ-008 div_val  input  CNT_W  requested period N in clk cycles.
REQ-009 high_val  input  CNT_W  requested high time H in clk cycles.
REQ-010 clk_out  output  1  divided clock, driven directly from a flop.
REQ-011 tick  output  1  one-cycle pulse marking each clk_out rising edge.
REQ-012 per_end  output  1  one-cycle pulse in the last cycle of each period.
REQ-013 upd_pend  output  1  high while a captured ratio awaits application.

Function
REQ-014 The active settings (N_act, H_act) and a phase counter ph (0..N_act-1) SHALL be registered.
REQ-015 With en=1, ph SHALL increment by 1 per cycle and wrap from N_act-1 to 0 (the period boundary).
REQ-016 In every cycle, clk_out SHALL equal 1 iff ph >= N_act-H_act, so each period has N_act-H_act low cycles followed by H_act high cycles.
REQ-017 clk_out SHALL be a registered output, computed from the next value of ph, so that it is glitch-free.
REQ-018 tick SHALL be 1 iff ph == N_act-H_act, and per_end SHALL be 1 iff ph == N_act-1 and en=1.
REQ-019 A div_load pulse SHALL capture clamped values into shadow registers and set upd_pend on the next edge.
REQ-020 Clamping SHALL be: N = max(div_val, 2); H = 1 if high_val == 0; H = N-1 if high_val >= N; otherwise H = high_val.
REQ-021 Shadow values SHALL transfer to N_act/H_act only at a period boundary, with ph going to 0; upd_pend SHALL clear on that same edge.
REQ-022 A load in a boundary cycle (ph == N_act-1, en=1) SHALL be applied at that boundary, and upd_pend SHALL stay 0.
REQ-023 For multiple loads before a boundary, the last load SHALL win.
REQ-024 The current period SHALL always complete with its old settings, with no truncated or stretched pulse.
REQ-025 With en=0: ph, clk_out and upd_pend SHALL hold; tick=0; per_end=0; a div_load is still captured.
REQ-026 When en rises, counting SHALL resume from the held ph.
REQ-027 No intermediate arithmetic SHALL overflow CNT_W bits; N = 2^CNT_W-1 SHALL be legal.

Reset
REQ-028 While rst=1 at an edge: ph=0, clk_out=0, tick=0, per_end=0, upd_pend=0, N_act=DEF_DIV, H_act=DEF_HIGH; shadow registers SHALL load the same values.
REQ-029 rst SHALL take priority over en and div_load in the same cycle, and any pending update SHALL be discarded.
REQ-030 After rst deasserts with en=1, the first edge SHALL give ph=1, and the defaults SHALL take effect immediately.

Verification
REQ-031 Defaults: rst 2 cycles, then en=1 -> clk_out 0,0,1,1 repeating; tick at ph=2; per_end at ph=3; period 4.
REQ-032 Mid-period load of div_val=10, high_val=3 at ph=1 -> upd_pend=1; 2 more old cycles; then 7 low/3 high repeating; upd_pend=0 from the boundary.
REQ-033 Clamp: div_val=1, high_val=5 -> N=2, H=1; clk_out toggles every cycle; tick every 2nd cycle.
REQ-034 en=0 for 5 cycles during the high phase -> clk_out stays 1, tick=0, per_end=0; the remaining high count completes after resume.
REQ-035 Load of div_val=8 then rst before the boundary -> upd_pend=0; N_act=4, H_act=2; 4-cycle period resumes.
REQ-036 Boundary-coincident load of div_val=6, high_val=6 at ph=3 -> next period is 1 low/5 high; upd_pend never asserts.
